// File: rtl/pluto_quad_pkg.sv
// Shared definitions for the quadrature index counter.
// Holds the default counter width, the snapshot word field offsets,
// the decode result type and the transition decode function.
package pluto_quad_pkg;

   // Default width of the position counter and the index-position register.
   localparam int QW_DEFAULT = 14;

   // Field offsets inside the snapshot word (for the default width).
   localparam int CNT_LSB  = 0;
   localparam int IDX_LSB  = QW_DEFAULT;
   localparam int FLAG_BIT = 2 * QW_DEFAULT;

   // Result of comparing the previous and current {A,B} samples.
   typedef enum logic [1:0] {
      HOLD    = 2'b00,
      INC     = 2'b01,
      DEC     = 2'b10,
      ILLEGAL = 2'b11
   } quad_dec_e;

   // Map {previous AB, current AB} onto a count step.
   // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a change of both bits
   // in one sample cannot be attributed to a direction.
   function automatic quad_dec_e quad_decode(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
      quad_dec_e res;
      case ({prev_ab, cur_ab})
         4'b0000, 4'b0101, 4'b1111, 4'b1010: res = HOLD;
         4'b0001, 4'b0111, 4'b1110, 4'b1000: res = INC;
         4'b0100, 4'b1101, 4'b1011, 4'b0010: res = DEC;
         default:                            res = ILLEGAL;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// Single-bit two-flop synchroniser with an optional digital glitch filter.
// Optional feature macro: QUAD_FILTER_EN. When defined, the output only
// follows the synchronised input after FILT_LEN consecutive identical
// captures by the second synchroniser flop; otherwise the second flop
// drives the output directly.
module quad_sync_filter
`ifdef QUAD_FILTER_EN
#(
   parameter int FILT_LEN = 3
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout
);

   logic s1;
   logic s2;

   // Two-flop synchroniser for the asynchronous input.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

`ifdef QUAD_FILTER_EN
   localparam logic [3:0] FILT_THR = 4'(FILT_LEN);

   logic [3:0] run;
   logic [3:0] run_next;
   logic       filt;

   // Length of the run of identical values captured by s2, counting the
   // capture happening at this edge (s1 is what s2 is about to take).
   always_comb begin
      run_next = 4'd1;
      if (s1 == s2) begin
         if (run == 4'd15) begin
            run_next = run;
         end else begin
            run_next = run + 4'd1;
         end
      end else begin
         run_next = 4'd1;
      end
   end

   // Run counter and filtered level; the level moves once the run is long enough.
   always_ff @(posedge clk) begin
      if (reset) begin
         run  <= 4'd0;
         filt <= 1'b0;
      end else begin
         run <= run_next;
         if (run_next >= FILT_THR) begin
            filt <= s1;
         end
      end
   end

   assign dout = filt;
`else
   assign dout = s2;
`endif

endmodule

// File: rtl/quad_index_counter.sv
// Per-axis quadrature decoder with index latch and coherent snapshot word.
// Optional feature macro: QUAD_FILTER_EN (adds a FILT_LEN glitch filter
// on each of A, B and Z after synchronisation).
// Snapshot word: [QW-1:0] count, [2QW-1:QW] index_pos, [2QW] index_flag.
module quad_index_counter
   import pluto_quad_pkg::*;
#(
   parameter int QW = QW_DEFAULT
`ifdef QUAD_FILTER_EN
   ,parameter int FILT_LEN = 3
`endif
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          quadA,
   input  logic          quadB,
   input  logic          quadZ,
   input  logic          snap,
   output logic [2*QW:0] quad_out,
   output logic          qerr
);

   logic [2:0]    raw_in;
   logic [2:0]    sync_in;
   logic [1:0]    ab_cur;
   logic [1:0]    ab_hist;
   logic          z_hist;
   quad_dec_e     step;
   logic          z_rise;
   quad_dec_e     step_q;
   logic          zrise_q;
   logic [QW-1:0] count;
   logic [QW-1:0] count_next;
   logic [QW-1:0] index_pos;
   logic          index_flag;
   logic          err;
   logic          err_set;

   assign raw_in = {quadZ, quadB, quadA};

   for (genvar i = 0; i < 3; i++) begin : g_sync
`ifdef QUAD_FILTER_EN
      quad_sync_filter #(.FILT_LEN(FILT_LEN)) u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (raw_in[i]),
         .dout  (sync_in[i])
      );
`else
      quad_sync_filter u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (raw_in[i]),
         .dout  (sync_in[i])
      );
`endif
   end

   assign ab_cur = {sync_in[0], sync_in[1]};

   // History flops (s3) holding the previous synchronised A/B/Z levels.
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_hist <= 2'b00;
         z_hist  <= 1'b0;
      end else begin
         ab_hist <= ab_cur;
         z_hist  <= sync_in[2];
      end
   end

   // Transition decode and index edge detection from current vs history.
   always_comb begin
      step   = quad_decode(ab_hist, ab_cur);
      z_rise = sync_in[2] & ~z_hist;
   end

   // Register the decode result and index edge together so the index latch
   // always sees the count produced by the same cycle's step.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q  <= HOLD;
         zrise_q <= 1'b0;
      end else begin
         step_q  <= step;
         zrise_q <= z_rise;
      end
   end

   // Next count value (wraps in both directions) and illegal-step detect.
   always_comb begin
      count_next = count;
      err_set    = 1'b0;
      case (step_q)
         INC:     count_next = count + QW'(1);
         DEC:     count_next = count - QW'(1);
         ILLEGAL: err_set    = 1'b1;
         default: count_next = count;
      endcase
   end

   // Live position counter and index position latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         count     <= {QW{1'b0}};
         index_pos <= {QW{1'b0}};
      end else begin
         count <= count_next;
         if (zrise_q) begin
            index_pos <= count_next;
         end
      end
   end

   // Sticky event flags: cleared by a snapshot, but a new event in the
   // snapshot cycle wins over the clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         index_flag <= 1'b0;
         err        <= 1'b0;
      end else begin
         index_flag <= zrise_q | (index_flag & ~snap);
         err        <= err_set | (err & ~snap);
      end
   end

   // Snapshot register: captures the pre-update live values on snap only.
   always_ff @(posedge clk) begin
      if (reset) begin
         quad_out <= {(2*QW+1){1'b0}};
         qerr     <= 1'b0;
      end else if (snap) begin
         quad_out <= {index_flag, index_pos, count};
         qerr     <= err;
      end
   end

endmodule

// File: tb/tb_quad_index_counter.sv
// Scoreboard bench for quad_index_counter: stimulus pushes the hand-computed
// expected snapshot when it strobes snap; a monitor compares on every
// snapshot edge and checks the output holds steady between snapshots.
module tb_quad_index_counter;

   localparam int QW       = 14;
   localparam int W        = 2 * QW + 1;
   localparam int FILT_LEN = 3;
`ifdef QUAD_FILTER_EN
   localparam int LAT = 2 + FILT_LEN;
`else
   localparam int LAT = 3;
`endif

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         quadA = 1'b0;
   logic         quadB = 1'b0;
   logic         quadZ = 1'b0;
   logic         snap  = 1'b0;
   logic [W-1:0] quad_out;
   logic         qerr;

   int           n_vec = 0;
   int           n_bad = 0;
   logic [W:0]   exp_q[$];
   logic [W-1:0] hold_word = '0;
   logic         hold_err  = 1'b0;
   int           ph = 0;
   logic [1:0]   seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   always #5 clk = ~clk;

`ifdef QUAD_FILTER_EN
   quad_index_counter #(.QW(QW), .FILT_LEN(FILT_LEN)) dut (
`else
   quad_index_counter #(.QW(QW)) dut (
`endif
      .clk      (clk),
      .reset    (reset),
      .quadA    (quadA),
      .quadB    (quadB),
      .quadZ    (quadZ),
      .snap     (snap),
      .quad_out (quad_out),
      .qerr     (qerr)
   );

   function automatic logic [W-1:0] pack(input logic f, input logic [QW-1:0] p,
                                         input logic [QW-1:0] c);
      return {f, p, c};
   endfunction

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [1:0] ab);
      @(negedge clk);
      {quadA, quadB} = ab;
      repeat (7) @(negedge clk);
   endtask

   task automatic fwd(input int n);
      for (int i = 0; i < n; i++) begin
         ph = (ph + 1) % 4;
         apply(seq[ph]);
      end
   endtask

   task automatic rev(input int n);
      for (int i = 0; i < n; i++) begin
         ph = (ph + 3) % 4;
         apply(seq[ph]);
      end
   endtask

   task automatic do_snap(input logic [W-1:0] w, input logic e);
      @(negedge clk);
      snap = 1'b1;
      exp_q.push_back({e, w});
      @(negedge clk);
      snap = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Monitor: compare each snapshot against the scoreboard, and otherwise
   // require the outputs to hold their last snapshot value.
   always @(posedge clk) begin
      logic       s_seen;
      logic       r_seen;
      logic [W:0] e;
      s_seen = snap;
      r_seen = reset;
      #1;
      if (r_seen) begin
         hold_word = '0;
         hold_err  = 1'b0;
      end else if (s_seen) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL snapshot: unexpected snap, got %h", {qerr, quad_out});
         end else begin
            e = exp_q.pop_front();
            if ({qerr, quad_out} !== e) begin
               n_bad++;
               $display("FAIL snapshot: got qerr=%0b word=%h, expected qerr=%0b word=%h",
                        qerr, quad_out, e[W], e[W-1:0]);
            end
            hold_word = e[W-1:0];
            hold_err  = e[W];
         end
      end else begin
         n_vec++;
         if ({qerr, quad_out} !== {hold_err, hold_word}) begin
            n_bad++;
            $display("FAIL stable: got qerr=%0b word=%h, expected qerr=%0b word=%h",
                     qerr, quad_out, hold_err, hold_word);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_out", {qerr, quad_out}, '0);
      do_snap(pack(1'b0, 14'd0, 14'd0), 1'b0);

      // Four full forward cycles.
      fwd(16);
      do_snap(pack(1'b0, 14'd0, 14'd16), 1'b0);

      // Reverse wrap below zero, then forward wrap back to zero.
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk); reset = 1'b0;
      fwd(2);
      rev(3);
      do_snap(pack(1'b0, 14'd0, 14'h3FFF), 1'b0);
      fwd(1);
      do_snap(pack(1'b0, 14'd0, 14'd0), 1'b0);

      // Index pulse at count 37, then a snapshot with no index.
      fwd(37);
      @(negedge clk); quadZ = 1'b1;
      repeat (10) @(negedge clk); quadZ = 1'b0;
      repeat (8) @(negedge clk);
      do_snap(pack(1'b1, 14'd37, 14'd37), 1'b0);
      do_snap(pack(1'b0, 14'd37, 14'd37), 1'b0);

      // Illegal jump 01 -> 10, then clean motion clears qerr.
      ph = 3;
      apply(seq[ph]);
      do_snap(pack(1'b0, 14'd37, 14'd37), 1'b1);
      fwd(1);
      do_snap(pack(1'b0, 14'd37, 14'd38), 1'b0);

      // Synced Z rising edge lands in the snap cycle.
      @(negedge clk); quadZ = 1'b1;
      repeat (2) @(negedge clk);
      do_snap(pack(1'b0, 14'd37, 14'd38), 1'b0);
      repeat (8) @(negedge clk);
      @(negedge clk); quadZ = 1'b0;
      repeat (8) @(negedge clk);
      do_snap(pack(1'b1, 14'd38, 14'd38), 1'b0);

      // Back-to-back snapshots.
      @(negedge clk); snap = 1'b1; exp_q.push_back({1'b0, pack(1'b0, 14'd38, 14'd38)});
      @(negedge clk);              exp_q.push_back({1'b0, pack(1'b0, 14'd38, 14'd38)});
      @(negedge clk); snap = 1'b0;
      repeat (2) @(negedge clk);

      // Reset while AB = 01: outputs clear, then one step from s3 = 0.
      fwd(1);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      check("midrun_reset", {qerr, quad_out}, '0);
      @(negedge clk); reset = 1'b0;
      repeat (8) @(negedge clk);
      do_snap(pack(1'b0, 14'd0, 14'd1), 1'b0);

      // Latency: snap at edge n+LAT still sees the old count, n+LAT+1 the new.
      ph = 2;
      @(negedge clk); {quadA, quadB} = seq[ph];
      repeat (LAT - 1) @(negedge clk);
      @(negedge clk); snap = 1'b1; exp_q.push_back({1'b0, pack(1'b0, 14'd0, 14'd1)});
      @(negedge clk);              exp_q.push_back({1'b0, pack(1'b0, 14'd0, 14'd2)});
      @(negedge clk); snap = 1'b0;
      repeat (8) @(negedge clk);

`ifdef QUAD_FILTER_EN
      // Two-cycle glitch on A is filtered out.
      @(negedge clk); quadA = 1'b0;
      repeat (2) @(negedge clk); quadA = 1'b1;
      repeat (10) @(negedge clk);
      do_snap(pack(1'b0, 14'd0, 14'd2), 1'b0);
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d snapshots outstanding, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
